// File: rtl/ram_pkg.sv
// Shared definitions for the CPU-bus RAM responder.
//   BUS_W    : width of the CPU address and data buses
//   RW_*     : encoding of the wire_RW direction strobe
//   state_e  : responder FSM states (clear sweep, ready for accesses)
package ram_pkg;

  localparam int unsigned BUS_W = 16;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  function automatic logic is_write(input logic rw);
    return rw == RW_WRITE;
  endfunction

endpackage

// File: rtl/ram_array.sv
// Plain single-port synchronous memory, write-first.
//   clk   : clock, all updates on rising edge
//   we    : write enable for the shared address
//   addr  : word address (read and write share it)
//   wdata : write data
//   rdata : registered read data; returns wdata on a write edge
module ram_array #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // No reset on the read register so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata_q   <= wdata;
    end else begin
      rdata_q   <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// Memory end of the CPU bus: word-addressed RAM with a clear sweep after reset.
//   clock            : system clock
//   reset            : synchronous, active-high reset
//   bus_RAM_ADDRESS  : CPU word address, low ADDR_W bits used (wraps modulo DEPTH)
//   bus_RAM_DATA_IN  : CPU write data
//   wire_RW          : 1 = write, 0 = read
//   bus_RAM_DATA_OUT : read data, one cycle latency, write-first
//   busy             : high while the array is being swept to INIT_VALUE
//   data_debug       : last word committed by a CPU write
module ram_responder
  import ram_pkg::*;
#(
  parameter int unsigned        ADDR_W     = 10,
  parameter int unsigned        DATA_W     = BUS_W,
  parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [BUS_W-1:0]  bus_RAM_ADDRESS,
  input  logic [DATA_W-1:0] bus_RAM_DATA_IN,
  input  logic              wire_RW,
  output logic [DATA_W-1:0] bus_RAM_DATA_OUT,
  output logic              busy,
  output logic [DATA_W-1:0] data_debug
);

  state_e            state_q;
  logic [ADDR_W-1:0] clear_ptr_q;
  logic              busy_q;
  logic [DATA_W-1:0] debug_q;
  logic              rd_valid_q;

  logic              cpu_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Upper address bits are deliberately ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus_RAM_ADDRESS;

  // Sweep owns the array port while clearing; a reset edge commits nothing.
  always_comb begin
    cpu_we    = (state_q == ST_READY) && is_write(wire_RW);
    mem_we    = !reset && ((state_q == ST_CLEAR) || cpu_we);
    mem_addr  = bus_RAM_ADDRESS[ADDR_W-1:0];
    mem_wdata = bus_RAM_DATA_IN;
    if (state_q == ST_CLEAR) begin
      mem_addr  = clear_ptr_q;
      mem_wdata = INIT_VALUE;
    end
  end

  ram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clock),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      clear_ptr_q <= '0;
      busy_q      <= 1'b1;
      debug_q     <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          rd_valid_q <= 1'b0;
          if (clear_ptr_q == '1) begin
            state_q <= ST_READY;
            busy_q  <= 1'b0;
          end else begin
            clear_ptr_q <= clear_ptr_q + 1'b1;
          end
        end
        ST_READY: begin
          rd_valid_q <= 1'b1;
          if (cpu_we) begin
            debug_q <= bus_RAM_DATA_IN;
          end
        end
        default: begin
          state_q <= ST_CLEAR;
        end
      endcase
    end
  end

  // The array read register has no reset; the output is forced to zero
  // until the edge after READY is entered, which keeps the data output
  // behaving as a resettable register held at 0 through the sweep.
  assign bus_RAM_DATA_OUT = rd_valid_q ? mem_rdata : '0;
  assign busy             = busy_q;
  assign data_debug       = debug_q;

endmodule

// File: tb/tb_ram_responder.sv
module tb_ram_responder;

  logic        clock;
  logic        reset;
  logic [15:0] bus_RAM_ADDRESS;
  logic [15:0] bus_RAM_DATA_IN;
  logic        wire_RW;
  logic [15:0] bus_RAM_DATA_OUT;
  logic        busy;
  logic [15:0] data_debug;

  int unsigned checks = 0;
  int unsigned passed = 0;

  localparam logic [15:0] INIT = 16'hA5A5;

  ram_responder #(
    .ADDR_W     (4),
    .DATA_W     (16),
    .INIT_VALUE (16'hA5A5)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .bus_RAM_ADDRESS  (bus_RAM_ADDRESS),
    .bus_RAM_DATA_IN  (bus_RAM_DATA_IN),
    .wire_RW          (wire_RW),
    .bus_RAM_DATA_OUT (bus_RAM_DATA_OUT),
    .busy             (busy),
    .data_debug       (data_debug)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic sweep_and_check(input string tag);
    for (int e = 1; e <= 16; e++) begin
      step();
      check({tag, "_busy"}, {15'b0, busy}, (e < 16) ? 16'h0001 : 16'h0000);
      check({tag, "_dout"}, bus_RAM_DATA_OUT, 16'h0000);
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus_RAM_ADDRESS = '0;
    bus_RAM_DATA_IN = '0;
    wire_RW         = 1'b0;
    step();
    step();
    check("rst_busy",  {15'b0, busy}, 16'h0001);
    check("rst_dout",  bus_RAM_DATA_OUT, 16'h0000);
    check("rst_debug", data_debug, 16'h0000);

    // Release reset while a write to addr 7 is held on the bus: dropped.
    reset           = 1'b0;
    wire_RW         = 1'b1;
    bus_RAM_ADDRESS = 16'h0007;
    bus_RAM_DATA_IN = 16'h5555;
    sweep_and_check("sweep1");
    wire_RW = 1'b0;
    check("busy_drop_debug", data_debug, 16'h0000);

    // Every word reads INIT after the sweep, one per cycle.
    for (int a = 0; a < 16; a++) begin
      bus_RAM_ADDRESS = 16'(a);
      step();
      check($sformatf("init_rd%0d", a), bus_RAM_DATA_OUT, INIT);
    end

    // Write-first and one-cycle read.
    wire_RW = 1'b1; bus_RAM_ADDRESS = 16'h0003; bus_RAM_DATA_IN = 16'h1234;
    step();
    check("wr3_wfirst", bus_RAM_DATA_OUT, 16'h1234);
    check("wr3_debug",  data_debug, 16'h1234);
    wire_RW = 1'b0; bus_RAM_DATA_IN = 16'h0000;
    step();
    check("rd3", bus_RAM_DATA_OUT, 16'h1234);

    // Aliasing: bus address 0x0013 maps to word 3.
    wire_RW = 1'b1; bus_RAM_ADDRESS = 16'h0013; bus_RAM_DATA_IN = 16'hBEEF;
    step();
    check("alias_wfirst", bus_RAM_DATA_OUT, 16'hBEEF);
    wire_RW = 1'b0; bus_RAM_ADDRESS = 16'h0003;
    step();
    check("alias_rd3",   bus_RAM_DATA_OUT, 16'hBEEF);
    check("alias_debug", data_debug, 16'hBEEF);
    bus_RAM_ADDRESS = 16'h0413;
    step();
    check("alias_rd413", bus_RAM_DATA_OUT, 16'hBEEF);

    // Write addr 2, then reset; restart the sweep and reset again at edge 8.
    wire_RW = 1'b1; bus_RAM_ADDRESS = 16'h0002; bus_RAM_DATA_IN = 16'h2222;
    step();
    check("wr2_debug", data_debug, 16'h2222);
    reset = 1'b1;                     // write of 0x2222 held on the reset edge
    step();
    check("rst2_busy",  {15'b0, busy}, 16'h0001);
    check("rst2_debug", data_debug, 16'h0000);
    check("rst2_dout",  bus_RAM_DATA_OUT, 16'h0000);
    reset = 1'b0; wire_RW = 1'b0;
    for (int e = 1; e <= 7; e++) step();
    check("mid_busy", {15'b0, busy}, 16'h0001);
    reset = 1'b1;
    step();
    reset = 1'b0;
    sweep_and_check("sweep2");
    bus_RAM_ADDRESS = 16'h0002;
    step();
    check("rd2_cleared", bus_RAM_DATA_OUT, INIT);
    bus_RAM_ADDRESS = 16'h0003;
    step();
    check("rd3_cleared", bus_RAM_DATA_OUT, INIT);
    check("sweep2_debug", data_debug, 16'h0000);

    // Alternating write/read, data = addr * 0x0101, no bubbles.
    for (int a = 0; a < 16; a++) begin
      wire_RW = 1'b1; bus_RAM_ADDRESS = 16'(a); bus_RAM_DATA_IN = 16'(a * 16'h0101);
      step();
      check($sformatf("alt_wr%0d", a), bus_RAM_DATA_OUT, 16'(a * 16'h0101));
      wire_RW = 1'b0; bus_RAM_DATA_IN = 16'hFFFF;
      step();
      check($sformatf("alt_rd%0d", a), bus_RAM_DATA_OUT, 16'(a * 16'h0101));
    end
    check("alt_debug", data_debug, 16'h0F0F);

    // Read back the alternating pattern in reverse order.
    for (int a = 15; a >= 0; a--) begin
      bus_RAM_ADDRESS = 16'(a);
      step();
      check($sformatf("back_rd%0d", a), bus_RAM_DATA_OUT, 16'(a * 16'h0101));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
